// File: rtl/pll_seq_pkg.sv
// pll_seq_pkg: state encoding, default timing constants and helpers shared by the PLL reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        STAGE     = 3'd3,
        RUN       = 3'd4
    } pll_state_t;

    localparam int DEF_PLL_RST_CYCLES  = 32;
    localparam int DEF_LOCK_TIMEOUT    = 65536;
    localparam int DEF_STABLE_CYCLES   = 1024;
    localparam int DEF_STAGE_GAP       = 16;
    localparam int DEF_DEBOUNCE_CYCLES = 4096;
    localparam int DEF_CNT_W           = 17;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/pll_reset_sequencer_btn_debounce.sv
// btn_debounce: synchronizes the bouncy active-low button and emits one press pulse per sustained low.
module btn_debounce
    import pll_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn_n,
    output logic o_press
);
    localparam logic [CNT_W-1:0] L_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_cnt;
    logic             r_armed;
    logic             r_press;
    logic             w_low;

    assign w_low   = ~r_sync[1];
    assign o_press = r_press;

    // r_armed re-arms only once the button is seen released, so a held button yields a single press
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_armed <= 1'b1;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_btn_n};
            r_press <= 1'b0;
            if (!w_low) begin
                r_cnt   <= '0;
                r_armed <= 1'b1;
            end else if (r_armed) begin
                if (r_cnt == L_LAST) begin
                    r_press <= 1'b1;
                    r_armed <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset pulsing, lock qualification and staged core/peripheral reset release.
// Optional lock_losses counter enabled by defining PLL_SEQ_LOCK_LOSS_CNT_EN.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int PLL_RST_CYCLES  = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT    = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES   = DEF_STABLE_CYCLES,
    parameter int STAGE_GAP       = DEF_STAGE_GAP,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       pll_lock,
    input  logic       btn_n,
    output logic       pll_reset,
    output logic       rst_core,
    output logic       rst_periph,
    output logic       ready,
    output logic [7:0] retries
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0] lock_losses
`endif
);
    localparam logic [CNT_W-1:0] L_PLL = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_TMO = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] L_STB = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] L_GAP = CNT_W'(STAGE_GAP - 1);

    logic [1:0]       r_lock_sync;
    pll_state_t       r_state;
    pll_state_t       w_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       r_retries;
    logic [7:0]       w_retries_nxt;
    logic             r_pll_reset;
    logic             r_rst_core;
    logic             r_rst_periph;
    logic             r_ready;
    logic             w_lock_s;
    logic             w_press;
    logic             w_zero;
    logic             w_lost;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_btn (
        .clk    (clk),
        .reset  (reset),
        .i_btn_n(btn_n),
        .o_press(w_press)
    );

    assign w_lock_s = r_lock_sync[1];
    assign w_zero   = (r_cnt == '0);
    assign w_lost   = !w_lock_s && (r_state inside {STABLE, STAGE, RUN});

    // Button restart outranks lock loss; lock loss from STAGE/RUN waits for relock without re-pulsing the PLL
    always_comb begin
        w_nxt         = r_state;
        w_cnt_nxt     = r_cnt - 1'b1;
        w_retries_nxt = r_retries;
        if (w_press && r_state != PLL_RST) begin
            w_nxt     = PLL_RST;
            w_cnt_nxt = L_PLL;
        end else begin
            case (r_state)
                PLL_RST: if (w_zero) begin
                    w_nxt     = WAIT_LOCK;
                    w_cnt_nxt = L_TMO;
                end
                WAIT_LOCK: if (w_lock_s) begin
                    w_nxt     = STABLE;
                    w_cnt_nxt = L_STB;
                end else if (w_zero) begin
                    w_nxt         = PLL_RST;
                    w_cnt_nxt     = L_PLL;
                    w_retries_nxt = sat_inc8(r_retries);
                end
                STABLE: if (w_lost) begin
                    w_nxt     = WAIT_LOCK;
                    w_cnt_nxt = L_TMO;
                end else if (w_zero) begin
                    w_nxt     = STAGE;
                    w_cnt_nxt = L_GAP;
                end
                STAGE: if (w_lost) begin
                    w_nxt     = WAIT_LOCK;
                    w_cnt_nxt = L_TMO;
                end else if (w_zero) begin
                    w_nxt = RUN;
                end
                RUN: if (w_lost) begin
                    w_nxt     = WAIT_LOCK;
                    w_cnt_nxt = L_TMO;
                end
                default: begin
                    w_nxt     = PLL_RST;
                    w_cnt_nxt = L_PLL;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_lock_sync  <= '0;
            r_state      <= PLL_RST;
            r_cnt        <= L_PLL;
            r_retries    <= 8'd0;
            r_pll_reset  <= 1'b1;
            r_rst_core   <= 1'b1;
            r_rst_periph <= 1'b1;
            r_ready      <= 1'b0;
        end else begin
            r_lock_sync  <= {r_lock_sync[0], pll_lock};
            r_state      <= w_nxt;
            r_cnt        <= w_cnt_nxt;
            r_retries    <= w_retries_nxt;
            r_pll_reset  <= (w_nxt == PLL_RST);
            r_rst_core   <= !(w_nxt inside {STAGE, RUN});
            r_rst_periph <= (w_nxt != RUN);
            r_ready      <= (w_nxt == RUN);
        end
    end

    assign pll_reset  = r_pll_reset;
    assign rst_core   = r_rst_core;
    assign rst_periph = r_rst_periph;
    assign ready      = r_ready;
    assign retries    = r_retries;

`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
    logic [7:0] r_losses;

    always_ff @(posedge clk) begin
        if (reset) r_losses <= 8'd0;
        else if (w_lost) r_losses <= sat_inc8(r_losses);
    end

    assign lock_losses = r_losses;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb_pll_reset_sequencer: scenario tasks plus randomized traffic checked cycle by cycle against a phase/elapsed-time model.
module tb_pll_reset_sequencer;
    localparam int P = 4;
    localparam int T = 20;
    localparam int S = 8;
    localparam int G = 3;
    localparam int D = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       pll_lock = 1'b0;
    logic       btn_n = 1'b1;
    logic       pll_reset;
    logic       rst_core;
    logic       rst_periph;
    logic       ready;
    logic [7:0] retries;
    logic [7:0] w_ll;
    logic [19:0] w_obs;
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
    logic [7:0] lock_losses;
    assign w_ll = lock_losses;
`else
    assign w_ll = 8'd0;
`endif
    assign w_obs = {pll_reset, rst_core, rst_periph, ready, retries, w_ll};

    pll_reset_sequencer #(
        .PLL_RST_CYCLES (P),
        .LOCK_TIMEOUT   (T),
        .STABLE_CYCLES  (S),
        .STAGE_GAP      (G),
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (17)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pll_lock  (pll_lock),
        .btn_n     (btn_n),
        .pll_reset (pll_reset),
        .rst_core  (rst_core),
        .rst_periph(rst_periph),
        .ready     (ready),
        .retries   (retries)
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
        ,
        .lock_losses(lock_losses)
`endif
    );

    always #5 clk = ~clk;

    // Model phases: 0 PLL pulse, 1 waiting for lock, 2 qualifying lock, 3 core released, 4 running
    int   m_phase = 0;
    int   m_t = 0;
    int   m_retries = 0;
    int   m_losses = 0;
    int   m_low_run = 0;
    logic m_press_q = 1'b0;
    logic [1:0] m_lk = 2'b00;
    logic [1:0] m_bh = 2'b00;
    int   n_chk = 0;
    int   n_pass = 0;
    int   cyc = 0;

    function automatic void go(input int p);
        m_phase = p;
        m_t = 0;
    endfunction

    function automatic void model_step();
        logic ls;
        logic bs;
        logic pr;
        cyc++;
        if (reset) begin
            go(0);
            m_retries = 0;
            m_losses = 0;
            m_low_run = 0;
            m_press_q = 1'b0;
            m_lk = 2'b00;
            m_bh = 2'b00;
            return;
        end
        ls = m_lk[1];
        bs = m_bh[1];
        pr = m_press_q;
        m_lk = {m_lk[0], pll_lock};
        m_bh = {m_bh[0], btn_n};
        m_low_run = bs ? 0 : m_low_run + 1;
        m_press_q = (m_low_run == D);
        if (m_phase >= 2 && !ls && m_losses < 255) m_losses++;
        if (pr && m_phase != 0) go(0);
        else case (m_phase)
            0: if (m_t == P - 1) go(1); else m_t++;
            1: if (ls) go(2);
               else if (m_t == T - 1) begin
                   if (m_retries < 255) m_retries++;
                   go(0);
               end else m_t++;
            2: if (!ls) go(1); else if (m_t == S - 1) go(3); else m_t++;
            3: if (!ls) go(1); else if (m_t == G - 1) go(4); else m_t++;
            default: if (!ls) go(1);
        endcase
    endfunction

    function automatic logic [19:0] m_exp();
        logic [7:0] ll;
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
        ll = 8'(m_losses);
`else
        ll = 8'd0;
`endif
        return {m_phase == 0, m_phase < 3, m_phase != 4, m_phase == 4, 8'(m_retries), ll};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        pll_lock = 1'b0;
        btn_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_chk++;
            if (w_obs !== m_exp()) $display("FAIL reset_model cyc=%0d dut=%h model=%h", cyc, w_obs, m_exp());
            else n_pass++;
        end
        n_chk++;
        if ({pll_reset, rst_core, rst_periph, ready, retries} !== 12'b1110_0000_0000)
            $display("FAIL reset_state got=%b%b%b%b r=%0d want 1110 r=0", pll_reset, rst_core, rst_periph, ready, retries);
        else n_pass++;
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
        n_chk++;
        if (lock_losses !== 8'd0) $display("FAIL reset_losses got=%0d want=0", lock_losses);
        else n_pass++;
`endif
    endtask

    task automatic test_powerup();
        int pr_fall = -1;
        int core_fall = -1;
        int per_fall = -1;
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            pll_lock = (i >= 10);
            tick();
            n_chk++;
            if (w_obs !== m_exp()) $display("FAIL powerup cyc=%0d dut=%h model=%h", cyc, w_obs, m_exp());
            else n_pass++;
            if (pr_fall < 0 && pll_reset === 1'b0) pr_fall = i;
            if (core_fall < 0 && rst_core === 1'b0) core_fall = i;
            if (per_fall < 0 && rst_periph === 1'b0) per_fall = i;
        end
        n_chk++;
        if (pr_fall !== P - 1) $display("FAIL powerup_pll_release got=%0d want=%0d", pr_fall, P - 1);
        else n_pass++;
        n_chk++;
        if (core_fall !== 10 + 2 + S) $display("FAIL powerup_core_release got=%0d want=%0d", core_fall, 10 + 2 + S);
        else n_pass++;
        n_chk++;
        if (per_fall - core_fall !== G) $display("FAIL powerup_stage_gap got=%0d want=%0d", per_fall - core_fall, G);
        else n_pass++;
        n_chk++;
        if (ready !== 1'b1 || retries !== 8'd0) $display("FAIL powerup_final ready=%b retries=%0d want 1/0", ready, retries);
        else n_pass++;
    endtask

    task automatic test_no_lock();
        int last_rise = -1;
        logic prev = 1'b1;
        logic released = 1'b0;
        pll_lock = 1'b0;
        do_reset();
        for (int i = 0; i < 262 * (P + T); i++) begin
            tick();
            n_chk++;
            if (w_obs !== m_exp()) $display("FAIL no_lock cyc=%0d dut=%h model=%h", cyc, w_obs, m_exp());
            else n_pass++;
            if (!prev && pll_reset === 1'b1) begin
                if (last_rise >= 0) begin
                    n_chk++;
                    if (i - last_rise !== P + T) $display("FAIL no_lock_period got=%0d want=%0d", i - last_rise, P + T);
                    else n_pass++;
                end
                last_rise = i;
            end
            prev = pll_reset;
            if (rst_core !== 1'b1 || rst_periph !== 1'b1) released = 1'b1;
        end
        n_chk++;
        if (retries !== 8'd255) $display("FAIL no_lock_saturate got=%0d want=255", retries);
        else n_pass++;
        n_chk++;
        if (released) $display("FAIL no_lock_resets got=released want=held");
        else n_pass++;
    endtask

    task automatic test_glitch();
        int g = -1;
        int core_fall = -1;
        pll_lock = 1'b1;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            pll_lock = !(g >= 0 && i == g);
            tick();
            n_chk++;
            if (w_obs !== m_exp()) $display("FAIL glitch cyc=%0d dut=%h model=%h", cyc, w_obs, m_exp());
            else n_pass++;
            if (g < 0 && m_phase == 2 && m_t == 4) g = i + 1;
            if (core_fall < 0 && rst_core === 1'b0) core_fall = i;
        end
        n_chk++;
        if (core_fall !== g + 3 + S) $display("FAIL glitch_release got=%0d want=%0d", core_fall, g + 3 + S);
        else n_pass++;
    endtask

    task automatic test_lock_drop_run();
        int drops[2];
        int nd = 0;
        int last_rise = -1;
        int n_rise = 0;
        logic prev_ready = 1'b0;
        logic pulsed = 1'b0;
        pll_lock = 1'b1;
        do_reset();
        for (int i = 0; i < 100; i++) begin
            if (nd < 2 && last_rise >= 0 && i == last_rise + 5) begin
                drops[nd] = i;
                nd++;
            end
            pll_lock = !(nd > 0 && i >= drops[nd-1] && i < drops[nd-1] + 4);
            tick();
            n_chk++;
            if (w_obs !== m_exp()) $display("FAIL lock_drop cyc=%0d dut=%h model=%h", cyc, w_obs, m_exp());
            else n_pass++;
            if (!prev_ready && ready === 1'b1) begin
                n_chk++;
                if (i !== ((nd == 0) ? P + S + G : drops[nd-1] + 6 + S + G))
                    $display("FAIL lock_drop_rerelease got=%0d", i);
                else n_pass++;
                last_rise = i;
                n_rise++;
            end
            if (prev_ready && ready === 1'b0) begin
                n_chk++;
                if (nd == 0 || i !== drops[nd-1] + 2) $display("FAIL lock_drop_reaction got=%0d", i);
                else n_pass++;
            end
            prev_ready = ready;
            if (i >= P && pll_reset !== 1'b0) pulsed = 1'b1;
        end
        n_chk++;
        if (n_rise !== 3 || nd !== 2) $display("FAIL lock_drop_events got rises=%0d drops=%0d want 3/2", n_rise, nd);
        else n_pass++;
        n_chk++;
        if (pulsed) $display("FAIL lock_drop_pll got=repulsed want=quiet");
        else n_pass++;
`ifdef PLL_SEQ_LOCK_LOSS_CNT_EN
        n_chk++;
        if (lock_losses !== 8'd2) $display("FAIL lock_losses got=%0d want=2", lock_losses);
        else n_pass++;
`endif
    endtask

    task automatic test_button();
        int s0 = 20;
        int s1 = 60;
        int first_rise = -1;
        int n_a = 0;
        int n_b = 0;
        logic prev = 1'b1;
        pll_lock = 1'b1;
        do_reset();
        for (int i = 0; i < 220; i++) begin
            if (i >= s0 && i < s0 + 3) btn_n = 1'b0;
            else if (i == s0 + 3) btn_n = 1'b1;
            else if (i >= s0 + 4 && i < s0 + 10) btn_n = 1'b0;
            else if (i >= s1 && i < s1 + 100) btn_n = 1'b0;
            else btn_n = 1'b1;
            tick();
            n_chk++;
            if (w_obs !== m_exp()) $display("FAIL button cyc=%0d dut=%h model=%h", cyc, w_obs, m_exp());
            else n_pass++;
            if (!prev && pll_reset === 1'b1) begin
                if (i < s1) n_a++;
                else if (i < s1 + 100) n_b++;
                if (first_rise < 0) first_rise = i;
            end
            prev = pll_reset;
        end
        n_chk++;
        if (n_a !== 1) $display("FAIL button_bounce got=%0d restarts want=1", n_a);
        else n_pass++;
        n_chk++;
        if (n_b !== 1) $display("FAIL button_hold got=%0d restarts want=1", n_b);
        else n_pass++;
        n_chk++;
        if (first_rise !== s0 + 4 + 2 + D) $display("FAIL button_latency got=%0d want=%0d", first_rise, s0 + 4 + 2 + D);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int hit = -1;
        pll_lock = 1'b1;
        btn_n = 1'b1;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            reset = (hit < 0 && m_phase == 3);
            if (reset) hit = i;
            tick();
            reset = 1'b0;
            n_chk++;
            if (w_obs !== m_exp()) $display("FAIL reset_mid cyc=%0d dut=%h model=%h", cyc, w_obs, m_exp());
            else n_pass++;
            if (i == hit) begin
                n_chk++;
                if (pll_reset !== 1'b1 || rst_core !== 1'b1 || ready !== 1'b0)
                    $display("FAIL reset_mid_state got=%b%b%b want=110", pll_reset, rst_core, ready);
                else n_pass++;
            end
        end
        n_chk++;
        if (hit < 0) $display("FAIL reset_mid_reach got=no_stage want=stage");
        else n_pass++;
    endtask

    task automatic test_random();
        int burst = 0;
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(39) == 0) pll_lock = !pll_lock;
            if (burst > 0) burst--;
            else if ($urandom_range(149) == 0) burst = $urandom_range(12, 1);
            btn_n = (burst == 0);
            reset = ($urandom_range(599) == 0);
            tick();
            n_chk++;
            if (w_obs !== m_exp()) $display("FAIL random cyc=%0d dut=%h model=%h", cyc, w_obs, m_exp());
            else n_pass++;
            n_chk++;
            if ((rst_core === 1'b1 && rst_periph === 1'b0) || (pll_reset === 1'b1 && rst_core === 1'b0))
                $display("FAIL random_order cyc=%0d got=%b%b%b", cyc, pll_reset, rst_core, rst_periph);
            else n_pass++;
        end
        reset = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_powerup();
        test_no_lock();
        test_glitch();
        test_lock_drop_run();
        test_button();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
Reset and bring-up controller for the 27 MHz board-clock domain. It sits directly upstream of the rPLL wrapper, whose 27 MHz input clock feeds this block. It drives the PLL RESET pin and consumes the PLL LOCK output. It releases staged, level-type resets for the core and peripheral logic only after lock has been stable for a set time. Per-domain synchronizers, outside this block, retime rst_core/rst_periph into PLL-derived domains.

Parameters:
PLL_RST_CYCLES, 32, cycles pll_reset is held high per PLL reset pulse
LOCK_TIMEOUT, 65536, cycles to wait for lock before re-pulsing PLL reset
STABLE_CYCLES, 1024, consecutive synchronized-lock cycles required before release
STAGE_GAP, 16, cycles between rst_core release and rst_periph release
DEBOUNCE_CYCLES, 4096, cycles btn_n must be continuously low to count as a press
CNT_W, 17, shared down-counter width; must satisfy 2^CNT_W > max(all cycle parameters)

Ports:
clk  input  1  27 MHz board oscillator (same net as PLL clkin)
reset  input  1  synchronous, active-high power-on reset
pll_lock  input  1  PLL LOCK; asynchronous to clk
btn_n  input  1  user reset button, active low, asynchronous, bouncy
pll_reset  output  1  to PLL RESET; high = PLL held in reset
rst_core  output  1  core reset, active high
rst_periph  output  1  peripheral reset, active high
ready  output  1  high only in RUN
retries  output  8  count of LOCK_TIMEOUT expiries, saturating at 255

Behaviour:
- Reset (synchronous, active-high) forces: state=PLL_RST; counter=PLL_RST_CYCLES-1; pll_reset=1; rst_core=1; rst_periph=1; ready=0; retries=0; sync flops=0; debounce counter=0. Reset has priority over all other events, including mid-sequence.
- pll_lock passes through a 2-flop synchronizer to give lock_s. btn_n passes through a 2-flop synchronizer, then a debouncer: press is a one-cycle pulse after DEBOUNCE_CYCLES consecutive low samples. Only one press is generated until btn_n has been seen high again.
- All outputs are registered. State changes take effect on outputs in the same cycle the new state is entered.
- PLL_RST: pll_reset=1; all resets=1. Counter decrements. At 0: go to WAIT_LOCK, counter=LOCK_TIMEOUT-1.
- WAIT_LOCK: pll_reset=0; resets=1.
  - lock_s=1: go to STABLE, counter=STABLE_CYCLES-1.
  - Otherwise, at counter 0: retries+1 (saturating), go to PLL_RST.
- STABLE: resets=1.
  - lock_s=0 in any cycle: go to WAIT_LOCK with counter reloaded to LOCK_TIMEOUT-1.
  - Otherwise, at counter 0: go to STAGE, rst_core=0, counter=STAGE_GAP-1.
- STAGE: rst_core=0, rst_periph=1. At counter 0: go to RUN, rst_periph=0, ready=1.
- RUN: all resets=0; ready=1.
- lock_s=0 in STAGE or RUN: rst_core, rst_periph =1 and ready=0 on the next edge; go to WAIT_LOCK. The PLL is not re-pulsed.
- Button press in any state except PLL_RST: go to PLL_RST (full restart); retries unchanged.
- Simultaneous lock loss and button press: button wins (PLL_RST).
- Release ordering invariant: rst_periph never falls before rst_core; rst_core never low while pll_reset=1.

Optional Feature:
PLL_SEQ_LOCK_LOSS_CNT_EN:
- Defined: adds output lock_losses [7:0], saturating at 255. It counts lock_s falling while in STABLE, STAGE or RUN. It clears only on reset.
- Undefined: the port and its counter are absent. All other behaviour is identical.

Decomposition:
- Package pll_seq_pkg holds:
  - state enum: PLL_RST, WAIT_LOCK, STABLE, STAGE, RUN (3-bit encoding)
  - default cycle constants
  - the saturating 8-bit increment function
- Sub-module btn_debounce holds the synchronizer, debounce counter and single-press pulse logic. It is instantiated once.

Test Plan:
Use params PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, STAGE_GAP=3, DEBOUNCE_CYCLES=5.
- Power-up: reset 2 cycles, pll_lock high at cycle 10 and stays high -> pll_reset low after 4 cycles; rst_core falls 8 cycles after lock_s rises; rst_periph falls 3 cycles later; ready=1; retries=0.
- Lock never asserts -> pll_reset re-pulses every 24 cycles; retries increments 1,2,3…; resets stay 1; saturation at 255 verified by forcing counter near limit.
- Lock glitch low for 1 cycle at STABLE cycle 5 -> state returns to WAIT_LOCK; full 8-cycle stable count restarts; no early release.
- Lock drop in RUN -> rst_core=rst_periph=1, ready=0 within 3 cycles of pll_lock falling (2 sync + 1); pll_reset stays 0; re-release after re-lock+8+3.
- btn_n bounces (low 3, high 1, low 6) -> exactly one press pulse; PLL_RST entered once; holding btn_n low 100 cycles gives no second press.
- Assert reset during STAGE -> next edge pll_reset=1, rst_core=1, ready=0. With PLL_SEQ_LOCK_LOSS_CNT_EN, lock_losses=0 after reset and 2 after two RUN lock drops.
